// File: rtl/wisc_pipe_pkg.sv
// Shared types and constants for the WISC-SP13 5-stage pipeline control blocks.
//   hz_state_t : hazard controller state (RUN, DRAIN, HALTED)
//   inflight_t : one tracked in-flight register writer {valid, dest, is_load}
//   src_hit    : true when a read source collides with a tracked writer
package wisc_pipe_pkg;

  localparam int unsigned NUM_REGS           = 8;
  localparam int unsigned REG_W              = $clog2(NUM_REGS);
  localparam int unsigned NUM_STAGES_TRACKED = 3;

  // Opcode the ID/EX register loads when its rst input (idex_nop) is high.
  localparam logic [4:0]  NOP_OPCODE         = 5'b00001;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } inflight_t;

  // r0 is an ordinary register here, so no zero-register exemption.
  function automatic logic src_hit(input logic             used,
                                   input logic [REG_W-1:0] src,
                                   input inflight_t        entry);
    return used & entry.valid & (src == entry.dest);
  endfunction

endpackage

// File: rtl/inflight_tracker.sv
// Three-entry shadow of the EX/MEM/WB pipeline registers' write-back info,
// plus source-versus-destination match logic for the decode stage.
// Ports:
//   clk, rst          : core clock, synchronous active-high reset
//   advance           : shift WB<-MEM<-EX<-ex_in (mirrors ID/EX enable)
//   ex_in             : entry describing what enters EX this edge
//   rs, rt            : decode source register fields
//   rs_used, rt_used  : the corresponding source is actually read
//   hit_ex/mem/wb     : a used source matches a valid entry in that stage
//   hit_ex_load       : the EX match is against a load
//   empty             : no valid entry in any tracked stage
module inflight_tracker
  import wisc_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  inflight_t        ex_in,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic             hit_ex,
  output logic             hit_mem,
  output logic             hit_wb,
  output logic             hit_ex_load,
  output logic             empty
);

  inflight_t ex_q;
  inflight_t mem_q;
  inflight_t wb_q;

  // Shift register; holds whenever the ID/EX register is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_in;
    end
  end

  assign hit_ex      = src_hit(rs_used, rs, ex_q)  | src_hit(rt_used, rt, ex_q);
  assign hit_mem     = src_hit(rs_used, rs, mem_q) | src_hit(rt_used, rt, mem_q);
  assign hit_wb      = src_hit(rs_used, rs, wb_q)  | src_hit(rt_used, rt, wb_q);
  assign hit_ex_load = hit_ex & ex_q.is_load;
  assign empty       = ~(ex_q.valid | mem_q.valid | wb_q.valid);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage WISC-SP13 core. Drives the
// enables and NOP-inject inputs of the pipeline registers: RAW stalls in
// decode, branch flushes, memory-busy freeze and HALT drain.
// Build option: define HAZARD_FORWARDING_EN when EX->EX and MEM->EX
// forwarding exists; only a load in EX then stalls a dependent decode.
// Ports:
//   clk, rst                   : core clock, synchronous active-high reset
//   id_valid                   : decode holds a real instruction
//   id_rs/id_rt, *_used        : decode sources and whether they are read
//   id_rd, id_reg_write        : decode destination and write-back enable
//   id_mem_to_reg, id_halt     : decode is a load / a HALT
//   ex_branch_taken            : EX redirects the PC
//   mem_busy                   : data memory not ready, freeze everything
//   pc_en, ifid_en, ifid_flush : PC and IF/ID controls
//   idex_en, idex_nop          : ID/EX enable and NOP inject
//   exmem_en, memwb_en         : downstream enables
//   halt_done                  : pipe drained after HALT, held until reset
// Enables/flushes are combinational so they act on the same edge as the
// pipeline registers they control.
module hazard_ctrl
  import wisc_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_halt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_nop,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halt_done
);

  hz_state_t state;
  inflight_t ex_in;
  logic      hit_ex;
  logic      hit_mem;
  logic      hit_wb;
  logic      hit_ex_load;
  logic      empty;
  logic      data_stall;
  logic      halt_req;

  inflight_tracker u_tracker (
    .clk         (clk),
    .rst         (rst),
    .advance     (idex_en),
    .ex_in       (ex_in),
    .rs          (id_rs),
    .rt          (id_rt),
    .rs_used     (id_rs_used),
    .rt_used     (id_rt_used),
    .hit_ex      (hit_ex),
    .hit_mem     (hit_mem),
    .hit_wb      (hit_wb),
    .hit_ex_load (hit_ex_load),
    .empty       (empty)
  );

  // A bubble in decode reads nothing, so it can never stall.
`ifdef HAZARD_FORWARDING_EN
  logic unused_hits;
  assign data_stall  = id_valid & hit_ex_load;
  assign unused_hits = hit_mem | hit_wb;
`else
  logic unused_hits;
  assign data_stall  = id_valid & (hit_ex | hit_mem | hit_wb);
  assign unused_hits = hit_ex_load;
`endif

  assign halt_req = id_valid & id_halt;

  // Whatever is injected as a NOP (bubble, squash, drain) never tracks.
  assign ex_in = '{valid:   id_valid & id_reg_write & ~idex_nop,
                   dest:    id_rd,
                   is_load: id_valid & id_reg_write & id_mem_to_reg & ~idex_nop};

  // Pipeline register controls, highest priority first.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_nop   = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      idex_nop   = 1'b1;
    end else if (mem_busy) begin
      // Freeze: nothing moves, nothing is injected.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state != RUN) begin
      // DRAIN/HALTED: stop fetch, keep feeding bubbles so older work retires.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_nop = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash both younger slots; any concurrent stall is moot.
      ifid_flush = 1'b1;
      idex_nop   = 1'b1;
    end else if (data_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_nop = 1'b1;
    end else if (halt_req) begin
      // HALT itself proceeds into EX; fetch stops behind it.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end
  end

  // Control state: HALT accepted only when it actually issues this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (!mem_busy && !ex_branch_taken && !data_stall && halt_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty && !mem_busy) begin
            state <= HALTED;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign halt_done = (state == HALTED) & ~rst;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage WISC-SP13 core: the block that drives the enable and NOP-inject (`rst`) inputs of the IF/ID and ID/EX pipeline registers. It tracks in-flight register writers, stalls decode on RAW hazards, flushes on taken branches, freezes on memory busy, and drains the pipe on HALT.

## Interface
- `NUM_REGS`, 8: architectural registers; destination field width is `$clog2(NUM_REGS)` = 3.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: decode holds a real instruction, not a bubble.
- `id_rs`, `id_rt` input 3 each: source register fields.
- `id_rs_used`, `id_rt_used` input 1 each: source is actually read.
- `id_rd` input 3: write-back destination after `reg_dst` muxing.
- `id_reg_write` input 1: decoded instruction writes the register file.
- `id_mem_to_reg` input 1: decoded instruction is a load.
- `id_halt` input 1: decoded instruction is HALT.
- `ex_branch_taken` input 1: the EX-stage branch or jump redirects the PC.
- `mem_busy` input 1: data memory is not ready; the whole pipe freezes.
- `pc_en` output 1: PC register enable.
- `ifid_en` output 1: IF/ID enable.
- `ifid_flush` output 1: IF/ID loads a NOP.
- `idex_en` output 1: ID/EX enable.
- `idex_nop` output 1: drives the ID/EX `rst` input, which loads NOP opcode 5'b00001 and clears `mem_write`, `reg_write`, `mem_to_reg` and `dump`.
- `exmem_en`, `memwb_en` output 1 each: downstream register enables.
- `halt_done` output 1: the pipe is drained after HALT; held until reset.

## Operation
- Tracker: 3 entries, EX/MEM/WB. Each entry holds {valid, dest[2:0], is_load}. It mirrors what the downstream pipeline registers hold.
- Advance (`idex_en`=1): WB←MEM, MEM←EX, EX←decode.
  - EX entry is valid only if `id_valid & id_reg_write & ~idex_nop`.
  - When `idex_nop`=1, the EX entry is loaded invalid.
- Hazard match: a source with `*_used`=1 equals the `dest` of a valid entry. Register 0 is a normal register; no r0 exemption.
- Data stall, non-forwarding build: a match against any of EX, MEM or WB.
  - Response: `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_nop`=1. A bubble enters EX.
- Priority, highest first: `rst` > `mem_busy` > `ex_branch_taken` > data stall > HALT > normal.
- `mem_busy`=1: all enables 0, the tracker holds, and no NOP is injected. This overrides a branch or stall in the same cycle; both are re-evaluated next cycle.
- `ex_branch_taken`=1, not busy: `pc_en`=1, `ifid_flush`=1, `idex_nop`=1.
  - The squashed decode instruction never enters the tracker.
  - A stall in the same cycle is discarded.
- State machine:
  - RUN: normal operation; `id_halt & id_valid` with no stall or branch → DRAIN.
  - DRAIN: `pc_en`=0, `ifid_en`=0, `idex_nop`=1 every cycle. Tracker all-invalid and `mem_busy`=0 → HALTED.
  - HALTED: `halt_done`=1, `pc_en`=0, `ifid_en`=0, `idex_nop`=1. Only `rst` exits.
  - A branch flush in RUN that squashes the HALT prevents the DRAIN entry.
- Reset values while `rst`=1 and in the cycle after:
  - State RUN, tracker all-invalid.
  - `pc_en`=0, `ifid_en`=1, `ifid_flush`=1, `idex_en`=1, `idex_nop`=1, `exmem_en`=1, `memwb_en`=1, `halt_done`=0.
  - The outputs above apply during the `rst`=1 cycles. In the cycle after `rst` drops, outputs follow normal RUN rules.
- `rst` asserted mid-stall or mid-DRAIN: state and tracker clear on the next edge.

## Timing
- Enables and flushes are combinational from the inputs, the state and the tracker. They take effect on the same `clk` edge as the pipeline registers.
- State and tracker update on `posedge clk`.
- Load-use with no forwarding: a consumer directly behind its producer stalls 3 cycles, until the producer leaves WB. Each additional intervening instruction saves 1 stall cycle.
- Branch penalty: 2 squashed slots (IF/ID and ID/EX) in one cycle.

## Configuration
- `HAZARD_FORWARDING_EN` defined: EX-to-EX and MEM-to-EX forwarding is assumed present. A stall happens only for a match against an EX entry with `is_load`=1, for exactly 1 cycle. MEM and WB matches never stall.
- Undefined: the full non-forwarding stall rule above.

## Structure
- Shared package `wisc_pipe_pkg`:
  - `hz_state_t` enum {RUN, DRAIN, HALTED}.
  - `inflight_t` struct {valid, dest, is_load}.
  - `NOP_OPCODE` = 5'b00001.
  - `NUM_STAGES_TRACKED` = 3.
- One sub-module, `inflight_tracker`: the 3-entry shift register plus match logic. It outputs `hit_ex`, `hit_mem`, `hit_wb`, `hit_ex_load` and `empty`.

## Test plan
- Reset, then `ADD r1` followed directly by `ADD r2,r1,r3` (forwarding off) → 3 cycles of `pc_en`=0, `idex_nop`=1, then the consumer issues.
- Same pair with `HAZARD_FORWARDING_EN` → no stall. `LD r1` followed by a use of r1 → exactly 1 stall cycle.
- `ex_branch_taken`=1 during a data stall → `ifid_flush`=1, `idex_nop`=1, `pc_en`=1. Next cycle there is no stall and the tracker EX entry is invalid.
- `mem_busy` held 4 cycles during a load-use stall → all enables 0 for 4 cycles, the tracker is unchanged, and the stall resumes afterwards.
- HALT with 2 writers in flight → DRAIN lasts 3 cycles, then `halt_done`=1 and stays high.
- `rst` pulsed in DRAIN → next cycle state is RUN, `halt_done`=0, tracker empty.
